// File: rtl/bus_arbiter_if.sv
// Shared bus bundle between four masters, the arbiter and eight slaves.
// master: the arbiter's view (it owns and drives the shared bus); slave: the attached agents' view.
interface bus_arbiter_if;
  logic [3:0]   m_req;
  logic [3:0]   m_as;
  logic [3:0]   m_rw;
  logic [119:0] m_addr;
  logic [127:0] m_wr_data;
  logic [3:0]   m_grnt;
  logic [3:0]   m_rdy;
  logic [31:0]  m_rd_data;
  logic [7:0]   s_cs;
  logic         s_as;
  logic         s_rw;
  logic [29:0]  s_addr;
  logic [31:0]  s_wr_data;
  logic [255:0] s_rd_data;
  logic [7:0]   s_rdy;
  logic         bus_err;

  modport master (
    input  m_req, m_as, m_rw, m_addr, m_wr_data, s_rd_data, s_rdy,
    output m_grnt, m_rdy, m_rd_data, s_cs, s_as, s_rw, s_addr, s_wr_data, bus_err
  );

  modport slave (
    output m_req, m_as, m_rw, m_addr, m_wr_data, s_rd_data, s_rdy,
    input  m_grnt, m_rdy, m_rd_data, s_cs, s_as, s_rw, s_addr, s_wr_data, bus_err
  );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for four masters onto eight address-decoded slaves, with
// per-transfer ready timeout and flush on request withdrawal.
module bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic          clk,
  input logic          rst,
  bus_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, GRANTED, XFER, DONE} state_e;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [1:0]  owner_q, owner_d;
  logic [1:0]  rr_ptr_q, rr_ptr_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  grnt_q, grnt_d;
  logic        err_q, err_d;

  logic [29:0] addr_arr [4];
  logic [31:0] wd_arr [4];
  logic [31:0] sd_arr [8];

  logic        own_req, own_as, own_rw;
  logic [29:0] own_addr;
  logic [31:0] own_wd;
  logic [2:0]  sel;
  logic        sel_rdy;
  logic        in_xfer;
  logic        done_rdy, done_to;
  logic        win_vld;
  logic [1:0]  win;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      addr_arr[i] = bus.m_addr[30*i +: 30];
      wd_arr[i]   = bus.m_wr_data[32*i +: 32];
    end
    for (int j = 0; j < 8; j++) begin
      sd_arr[j] = bus.s_rd_data[32*j +: 32];
    end
  end

  assign own_req  = bus.m_req[owner_q];
  assign own_as   = bus.m_as[owner_q];
  assign own_rw   = bus.m_rw[owner_q];
  assign own_addr = addr_arr[owner_q];
  assign own_wd   = wd_arr[owner_q];
  assign sel      = own_addr[29:27];
  assign sel_rdy  = bus.s_rdy[sel];

  // Combinational outputs are forced quiet while rst is high, whatever the state.
  assign in_xfer  = (state_q == XFER) && !rst;
  // A request withdrawal beats completion; ready beats a coincident timeout.
  assign done_rdy = in_xfer && own_req && sel_rdy;
  assign done_to  = in_xfer && own_req && !sel_rdy && (cnt_q == TO_LAST);

  always_comb begin
    bus.s_as      = 1'b0;
    bus.s_rw      = 1'b0;
    bus.s_addr    = '0;
    bus.s_wr_data = '0;
    bus.s_cs      = '0;
    if (in_xfer) begin
      bus.s_as      = 1'b1;
      bus.s_rw      = own_rw;
      bus.s_addr    = own_addr;
      bus.s_wr_data = own_wd;
      bus.s_cs      = 8'b1 << sel;
    end
  end

  assign bus.m_rdy     = (done_rdy || done_to) ? (4'b1 << owner_q) : 4'b0;
  assign bus.m_rd_data = (done_rdy && !own_rw) ? sd_arr[sel] : 32'b0;
  assign bus.m_grnt    = grnt_q;
  assign bus.bus_err   = err_q;

  // Highest-numbered offset is examined first so the nearest requester from rr_ptr wins.
  always_comb begin
    win_vld = 1'b0;
    win     = rr_ptr_q;
    for (int k = 3; k >= 0; k--) begin
      if (bus.m_req[rr_ptr_q + 2'(k)]) begin
        win_vld = 1'b1;
        win     = rr_ptr_q + 2'(k);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    grnt_d   = grnt_q;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          owner_d  = win;
          grnt_d   = 4'b1 << win;
          rr_ptr_d = win + 2'd1;
          state_d  = GRANTED;
        end
      end
      GRANTED: begin
        if (!own_req) begin
          grnt_d  = '0;
          state_d = IDLE;
        end else if (own_as) begin
          cnt_d   = '0;
          state_d = XFER;
        end
      end
      XFER: begin
        if (!own_req) begin
          grnt_d  = '0;
          state_d = IDLE;
        end else if (sel_rdy) begin
          state_d = DONE;
        end else if (cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: begin
        if (!own_req) begin
          grnt_d  = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
      grnt_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      grnt_q   <= grnt_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: expected grant/ready/error events go into a
// queue and a negedge monitor matches each observed event against it.
module tb_bus_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bus_arbiter_if bus();

  bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  typedef struct packed {
    logic [3:0]  grnt;
    logic [3:0]  rdy;
    logic [31:0] data;
    logic [7:0]  cs;
    logic        err;
  } ev_t;

  ev_t        exp_q[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  bit         mon_en   = 1'b0;
  logic [3:0] prev_grnt;
  ev_t        act_ev, exp_ev;
  int         order[5] = '{0, 1, 2, 3, 0};
  logic [3:0] g;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual %h required %h", nm, act, req);
  endtask

  task automatic push(input logic [3:0] gr, input logic [3:0] rd, input logic [31:0] d,
                      input logic [7:0] cs, input logic e);
    ev_t ev;
    ev.grnt = gr; ev.rdy = rd; ev.data = d; ev.cs = cs; ev.err = e;
    exp_q.push_back(ev);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: any grant change, ready pulse or error pulse is an event to match.
  initial begin
    prev_grnt = '0;
    forever begin
      @(negedge clk);
      if (mon_en && (bus.m_rdy != 4'b0 || bus.bus_err || bus.m_grnt != prev_grnt)) begin
        act_ev = {bus.m_grnt, bus.m_rdy, bus.m_rd_data, bus.s_cs, bus.bus_err};
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_event: actual %h required none", act_ev);
        end else begin
          exp_ev = exp_q.pop_front();
          chk("event", 64'(act_ev), 64'(exp_ev));
        end
      end
      if (mon_en) prev_grnt = bus.m_grnt;
    end
  end

  initial begin
    rst = 1'b1;
    bus.m_req = '0; bus.m_as = '0; bus.m_rw = '0;
    bus.m_addr = '0; bus.m_wr_data = '0; bus.s_rdy = '0;
    for (int j = 0; j < 8; j++) bus.s_rd_data[32*j +: 32] = 32'hA5A5_0000 | 32'(j);
    bus.s_rd_data[31:0]    = 32'h1111_1111;
    bus.s_rd_data[63:32]   = 32'hDEAD_BEEF;
    bus.s_rd_data[255:224] = 32'h7777_7777;
    step(); step();
    chk("rst_grnt", 64'(bus.m_grnt), 64'h0);
    chk("rst_err", 64'(bus.bus_err), 64'h0);
    chk("rst_rdy", 64'(bus.m_rdy), 64'h0);
    chk("rst_sas", 64'(bus.s_as), 64'h0);
    rst = 1'b0;
    mon_en = 1'b1;
    step();

    // Master 1 reads slave 1, ready on the second transfer cycle, then holds m_as in DONE.
    bus.m_req[1] = 1'b1; push(4'b0010, 4'b0, 32'h0, 8'h0, 1'b0); step();
    bus.m_as[1] = 1'b1; bus.m_rw[1] = 1'b0; bus.m_addr[59:30] = 30'h0800_0010; step();
    chk("rd_sas", 64'(bus.s_as), 64'h1);
    chk("rd_scs", 64'(bus.s_cs), 64'h02);
    chk("rd_saddr", 64'(bus.s_addr), 64'h0800_0010);
    chk("rd_wait_rdy", 64'(bus.m_rdy), 64'h0);
    chk("rd_wait_data", 64'(bus.m_rd_data), 64'h0);
    step();
    bus.s_rdy = 8'h02; push(4'b0010, 4'b0010, 32'hDEAD_BEEF, 8'h02, 1'b0); step();
    bus.s_rdy = 8'h00; step(); step();
    chk("done_no_rdy", 64'(bus.m_rdy), 64'h0);
    chk("done_sas", 64'(bus.s_as), 64'h0);
    bus.m_req[1] = 1'b0; bus.m_as[1] = 1'b0; push(4'b0, 4'b0, 32'h0, 8'h0, 1'b0); step();

    // Master 2 writes slave 7 which never answers; other slaves are ready.
    bus.m_req[2] = 1'b1; push(4'b0100, 4'b0, 32'h0, 8'h0, 1'b0); step();
    bus.m_as[2] = 1'b1; bus.m_rw[2] = 1'b1; bus.m_addr[89:60] = {3'd7, 27'h000_0123};
    bus.m_wr_data[95:64] = 32'hCAFE_F00D; bus.s_rdy = 8'h7F; step();
    chk("to_scs", 64'(bus.s_cs), 64'h80);
    chk("to_swd", 64'(bus.s_wr_data), 64'hCAFE_F00D);
    chk("to_srw", 64'(bus.s_rw), 64'h1);
    step(); step(); step();
    push(4'b0100, 4'b0100, 32'h0, 8'h80, 1'b0);
    push(4'b0100, 4'b0000, 32'h0, 8'h00, 1'b1);
    step(); step();
    bus.s_rdy = 8'h00; step();
    bus.m_req[2] = 1'b0; bus.m_as[2] = 1'b0; bus.m_rw[2] = 1'b0;
    push(4'b0, 4'b0, 32'h0, 8'h0, 1'b0); step();

    // Master 3 reads slave 0 with ready arriving on the timeout cycle.
    bus.m_req[3] = 1'b1; push(4'b1000, 4'b0, 32'h0, 8'h0, 1'b0); step();
    bus.m_as[3] = 1'b1; bus.m_addr[119:90] = {3'd0, 27'h000_0055}; step();
    step(); step(); step();
    bus.s_rdy = 8'h01; push(4'b1000, 4'b1000, 32'h1111_1111, 8'h01, 1'b0); step();
    bus.s_rdy = 8'h00; step(); step();
    bus.m_req[3] = 1'b0; bus.m_as[3] = 1'b0; push(4'b0, 4'b0, 32'h0, 8'h0, 1'b0); step();

    // Master 0 withdraws its request on the second transfer cycle.
    bus.m_req[0] = 1'b1; push(4'b0001, 4'b0, 32'h0, 8'h0, 1'b0); step();
    bus.m_as[0] = 1'b1; bus.m_addr[29:0] = {3'd2, 27'h000_0009}; step();
    step();
    bus.m_req[0] = 1'b0; #1;
    chk("flush_rdy", 64'(bus.m_rdy), 64'h0);
    push(4'b0, 4'b0, 32'h0, 8'h0, 1'b0); step();
    bus.m_as[0] = 1'b0;
    chk("flush_sas", 64'(bus.s_as), 64'h0);
    chk("flush_grnt", 64'(bus.m_grnt), 64'h0);
    step();

    // Reset in the middle of a master 1 transfer; a late ready must not leak out.
    bus.m_req[1] = 1'b1; push(4'b0010, 4'b0, 32'h0, 8'h0, 1'b0); step();
    bus.m_as[1] = 1'b1; bus.m_rw[1] = 1'b0; bus.m_addr[59:30] = {3'd4, 27'h000_0001}; step();
    chk("pre_rst_sas", 64'(bus.s_as), 64'h1);
    rst = 1'b1; bus.s_rdy = 8'h10; #1;
    chk("in_rst_sas", 64'(bus.s_as), 64'h0);
    chk("in_rst_scs", 64'(bus.s_cs), 64'h0);
    chk("in_rst_rdy", 64'(bus.m_rdy), 64'h0);
    chk("in_rst_data", 64'(bus.m_rd_data), 64'h0);
    push(4'b0, 4'b0, 32'h0, 8'h0, 1'b0); step();
    rst = 1'b0; bus.s_rdy = 8'h00; bus.m_req[1] = 1'b0; bus.m_as[1] = 1'b0;
    chk("post_rst_sas", 64'(bus.s_as), 64'h0);
    chk("post_rst_grnt", 64'(bus.m_grnt), 64'h0);
    step();

    // All masters request; each owner releases and re-requests, rotation restarts at 0.
    bus.m_req = 4'hF;
    push(4'b0001, 4'b0, 32'h0, 8'h0, 1'b0); step();
    for (int k = 0; k < 5; k++) begin
      g = 4'b0001 << order[k];
      chk("rr_grnt", 64'(bus.m_grnt), 64'(g));
      if (k < 4) begin
        bus.m_req = 4'hF & ~g;
        push(4'b0, 4'b0, 32'h0, 8'h0, 1'b0); step();
        chk("rr_gap", 64'(bus.m_grnt), 64'h0);
        bus.m_req = 4'hF;
        push(4'b0001 << order[k+1], 4'b0, 32'h0, 8'h0, 1'b0); step();
      end
    end
    bus.m_req = 4'h0;
    push(4'b0, 4'b0, 32'h0, 8'h0, 1'b0); step();
    step(); step();

    chk("sb_empty", 64'(exp_q.size()), 64'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
